cache_age_tracker: RTL and testbench

//  Per-set LRU age store and update pipeline sitting directly upstream of new_age_converter.
//  - Holds one packed age vector (8 ways x C_N_WAY bits) per cache set.
//  - Accepts hit/miss lookups from tag compare, reads the set's ages, runs them through an

---
 rtl/cache_age_tracker.sv | 193 +++++++++++++++++++
 tb/tb_cache_age_tracker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_age_tracker.sv
`default_nettype none
// ============================================================================
// Module   : cache_age_tracker
// Purpose  : Per-set 8-way LRU age store with a one-stage lookup/update
//            pipeline. Each accepted lookup reads the set's packed age vector,
//            runs it through the age converter, writes the result back and
//            returns the way to use (hit way, or the age-7 victim on a miss).
// Ports    : clk, reset           - clock, synchronous active-high reset
//            init_done            - age store initialised, lookups accepted
//            req_valid/req_ready  - lookup handshake
//            req_set_idx/ishit/way- lookup set, hit flag, hit way
//            rsp_valid/rsp_ready  - response handshake (held until ready)
//            rsp_set_idx/ishit/way- echoed set/hit flag, selected way
// Revision : 1.0 - initial release
// ============================================================================
module cache_age_tracker #(
   parameter int C_N_WAY    = 3,
   parameter int C_SET_BITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  init_done,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [C_SET_BITS-1:0] req_set_idx,
   input  logic                  req_ishit,
   input  logic [C_N_WAY-1:0]    req_way,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [C_SET_BITS-1:0] rsp_set_idx,
   output logic                  rsp_ishit,
   output logic [C_N_WAY-1:0]    rsp_way
);

   localparam int c_n_ways = 1 << C_N_WAY;
   localparam int c_age_w  = c_n_ways * C_N_WAY;
   localparam int c_n_sets = 1 << C_SET_BITS;
   localparam logic [C_SET_BITS-1:0] c_last_set = '1;
   localparam logic [C_N_WAY-1:0]    c_age_max  = '1;

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [C_SET_BITS-1:0] r_init_cnt;
   logic                  r_init_done;

   logic [c_age_w-1:0]    r_age_mem [c_n_sets];

   logic                  r_p1_valid;
   logic [C_SET_BITS-1:0] r_p1_set;
   logic                  r_p1_ishit;
   logic [C_N_WAY-1:0]    r_p1_way;

   logic                  r_rsp_valid;
   logic [C_SET_BITS-1:0] r_rsp_set_idx;
   logic                  r_rsp_ishit;
   logic [C_N_WAY-1:0]    r_rsp_way;

   logic                  w_advance;
   logic                  w_req_ready;
   logic                  w_accept;

   logic [c_age_w-1:0]    w_default_ages;
   logic [c_age_w-1:0]    w_cur_ages;
   logic [c_age_w-1:0]    w_new_ages;
   logic [C_N_WAY-1:0]    w_cur_age [c_n_ways];
   logic [C_N_WAY-1:0]    w_new_age [c_n_ways];
   logic                  w_conv_found;
   logic [C_N_WAY-1:0]    w_conv_victim;
   logic [C_N_WAY-1:0]    w_conv_ref_way;
   logic [C_N_WAY-1:0]    w_conv_ref_age;

   // Default vector: way i holds age i (way 7 is the initial LRU victim).
   generate
      for (genvar gi = 0; gi < c_n_ways; gi++) begin : g_ages
         assign w_default_ages[gi*C_N_WAY +: C_N_WAY] = C_N_WAY'(gi);
         assign w_cur_age[gi]                         = w_cur_ages[gi*C_N_WAY +: C_N_WAY];
         assign w_new_ages[gi*C_N_WAY +: C_N_WAY]     = w_new_age[gi];
      end
   endgenerate

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_INIT;
         r_init_cnt  <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_init_done <= (w_state_nxt == ST_RUN);
         if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + C_SET_BITS'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT: if (r_init_cnt == c_last_set) w_state_nxt = ST_RUN;
         ST_RUN:  w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // ---------------------------------------------------------------- handshake
   assign w_advance   = r_p1_valid & (~r_rsp_valid | rsp_ready);
   assign w_req_ready = r_init_done & (~r_p1_valid | w_advance);
   assign w_accept    = req_valid & w_req_ready;

   // ---------------------------------------------------------------- age converter
   // Combinational read of the set held in p1. Same-set back-to-back lookups
   // need no bypass: the write lands at the advance edge, before the next read.
   assign w_cur_ages = r_age_mem[r_p1_set];

   always_comb begin : new_age_converter
      w_conv_found  = 1'b0;
      w_conv_victim = r_p1_way;   // fallback if no way holds the maximum age
      for (int i = 0; i < c_n_ways; i++) begin
         if (!w_conv_found && (w_cur_age[i] == c_age_max)) begin
            w_conv_found  = 1'b1;
            w_conv_victim = C_N_WAY'(i);
         end
      end
      w_conv_ref_way = r_p1_ishit ? r_p1_way : w_conv_victim;
      w_conv_ref_age = w_cur_age[w_conv_ref_way];
      // Referenced way becomes MRU; only ways younger than it age by one.
      for (int i = 0; i < c_n_ways; i++) begin
         if (C_N_WAY'(i) == w_conv_ref_way) begin
            w_new_age[i] = '0;
         end else if (w_cur_age[i] < w_conv_ref_age) begin
            w_new_age[i] = w_cur_age[i] + C_N_WAY'(1);
         end else begin
            w_new_age[i] = w_cur_age[i];
         end
      end
   end

   // ---------------------------------------------------------------- age store
   // Reset blocks the write so an in-flight p1 entry is dropped unwritten.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == ST_INIT) begin
            r_age_mem[r_init_cnt] <= w_default_ages;
         end else if (w_advance) begin
            r_age_mem[r_p1_set] <= w_new_ages;
         end
      end
   end

   // ---------------------------------------------------------------- pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         r_p1_valid <= 1'b0;
         r_p1_set   <= '0;
         r_p1_ishit <= 1'b0;
         r_p1_way   <= '0;
      end else if (w_accept) begin
         r_p1_valid <= 1'b1;
         r_p1_set   <= req_set_idx;
         r_p1_ishit <= req_ishit;
         r_p1_way   <= req_way;
      end else if (w_advance) begin
         r_p1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid   <= 1'b0;
         r_rsp_set_idx <= '0;
         r_rsp_ishit   <= 1'b0;
         r_rsp_way     <= '0;
      end else if (w_advance) begin
         r_rsp_valid   <= 1'b1;
         r_rsp_set_idx <= r_p1_set;
         r_rsp_ishit   <= r_p1_ishit;
         r_rsp_way     <= r_p1_ishit ? r_p1_way : w_conv_victim;
      end else if (rsp_ready) begin
         r_rsp_valid   <= 1'b0;
      end
   end

   assign init_done   = r_init_done;
   assign req_ready   = w_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_set_idx = r_rsp_set_idx;
   assign rsp_ishit   = r_rsp_ishit;
   assign rsp_way     = r_rsp_way;

endmodule
`default_nettype wire

// File: tb/tb_cache_age_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cache_age_tracker
// Purpose  : Directed, table-driven self-checking bench for cache_age_tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_age_tracker;

   logic       clk = 1'b0;
   logic       reset;
   logic       init_done;
   logic       req_valid;
   logic       req_ready;
   logic [4:0] req_set_idx;
   logic       req_ishit;
   logic [2:0] req_way;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [4:0] rsp_set_idx;
   logic       rsp_ishit;
   logic [2:0] rsp_way;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cache_age_tracker #(.C_N_WAY(3), .C_SET_BITS(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .init_done   (init_done),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_set_idx (req_set_idx),
      .req_ishit   (req_ishit),
      .req_way     (req_way),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_set_idx (rsp_set_idx),
      .rsp_ishit   (rsp_ishit),
      .rsp_way     (rsp_way)
   );

   typedef struct {
      logic [4:0]  set;
      logic        ishit;
      logic [2:0]  way;
      logic [2:0]  exp_way;
      logic [23:0] exp_ages;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arguments in way7..way0 order, packed with way0 in the low bits.
   function automatic logic [23:0] ages(input int w7, input int w6, input int w5, input int w4,
                                        input int w3, input int w2, input int w1, input int w0);
      return {3'(w7), 3'(w6), 3'(w5), 3'(w4), 3'(w3), 3'(w2), 3'(w1), 3'(w0)};
   endfunction

   function automatic logic [23:0] mem_rd(input int s);
      return dut.r_age_mem[s];
   endfunction

   // Checks the init length: init_done low after 31 edges, high after 32.
   task automatic check_init(input string tag);
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (k < 32) begin
            check($sformatf("%s_init_done_c%0d", tag, k), {31'd0, init_done}, 32'd0);
            check($sformatf("%s_req_ready_c%0d", tag, k), {31'd0, req_ready}, 32'd0);
         end else begin
            check($sformatf("%s_init_done_c32", tag), {31'd0, init_done}, 32'd1);
            check($sformatf("%s_req_ready_c32", tag), {31'd0, req_ready}, 32'd1);
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      check($sformatf("v%0d_req_ready", idx), {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_set_idx = v.set; req_ishit = v.ishit; req_way = v.way;
      tick();
      req_valid = 1'b0;
      check($sformatf("v%0d_rsp_valid_early", idx), {31'd0, rsp_valid}, 32'd0);
      tick();
      check($sformatf("v%0d_rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("v%0d_rsp_way", idx), {29'd0, rsp_way}, {29'd0, v.exp_way});
      check($sformatf("v%0d_rsp_ishit", idx), {31'd0, rsp_ishit}, {31'd0, v.ishit});
      check($sformatf("v%0d_rsp_set", idx), {27'd0, rsp_set_idx}, {27'd0, v.set});
      check($sformatf("v%0d_ages", idx), {8'd0, mem_rd(int'(v.set))}, {8'd0, v.exp_ages});
      tick();
      check($sformatf("v%0d_rsp_drain", idx), {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      logic [23:0] dflt;
      dflt = ages(7, 6, 5, 4, 3, 2, 1, 0);

      vecs[0] = '{5'd2,  1'b1, 3'd5, 3'd5, ages(7, 6, 0, 5, 4, 3, 2, 1)};
      vecs[1] = '{5'd2,  1'b1, 3'd0, 3'd0, ages(7, 6, 1, 5, 4, 3, 2, 0)};
      vecs[2] = '{5'd2,  1'b0, 3'd3, 3'd7, ages(0, 7, 2, 6, 5, 4, 3, 1)};
      vecs[3] = '{5'd2,  1'b1, 3'd7, 3'd7, ages(0, 7, 2, 6, 5, 4, 3, 1)};
      vecs[4] = '{5'd31, 1'b1, 3'd7, 3'd7, ages(0, 7, 6, 5, 4, 3, 2, 1)};
      vecs[5] = '{5'd0,  1'b0, 3'd0, 3'd7, ages(0, 7, 6, 5, 4, 3, 2, 1)};
      vecs[6] = '{5'd31, 1'b0, 3'd1, 3'd6, ages(1, 0, 7, 6, 5, 4, 3, 2)};

      // ---- reset and initialisation, with a request held throughout
      reset = 1'b1; req_valid = 1'b1; req_set_idx = '0; req_ishit = 1'b0;
      req_way = '0; rsp_ready = 1'b1;
      repeat (3) tick();
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_fields", {23'd0, rsp_set_idx, rsp_ishit, rsp_way}, 32'd0);
      reset = 1'b0;
      check_init("init");
      req_valid = 1'b0;
      check("init_no_rsp", {31'd0, rsp_valid}, 32'd0);
      for (int s = 0; s < 32; s++) begin
         check($sformatf("init_set%0d", s), {8'd0, mem_rd(s)}, {8'd0, dflt});
      end

      // ---- back-to-back misses on set 3
      req_valid = 1'b1; req_set_idx = 5'd3; req_ishit = 1'b0; req_way = 3'd2;
      tick();
      check("b2b_ready_2nd", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      check("b2b_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
      check("b2b_rsp1_way", {29'd0, rsp_way}, 32'd7);
      check("b2b_rsp1_ishit", {31'd0, rsp_ishit}, 32'd0);
      check("b2b_rsp1_set", {27'd0, rsp_set_idx}, 32'd3);
      check("b2b_ages1", {8'd0, mem_rd(3)}, {8'd0, ages(0, 7, 6, 5, 4, 3, 2, 1)});
      tick();
      check("b2b_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
      check("b2b_rsp2_way", {29'd0, rsp_way}, 32'd6);
      check("b2b_ages2", {8'd0, mem_rd(3)}, {8'd0, ages(1, 0, 7, 6, 5, 4, 3, 2)});
      tick();
      check("b2b_drain", {31'd0, rsp_valid}, 32'd0);

      // ---- table of isolated lookups
      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
      check("untouched_set1", {8'd0, mem_rd(1)}, {8'd0, dflt});
      check("untouched_set4", {8'd0, mem_rd(4)}, {8'd0, dflt});

      // ---- backpressure on set 9 with a second request queued in p1
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_set_idx = 5'd9; req_ishit = 1'b0; req_way = 3'd0;
      tick();
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("bp_valid_c%0d", c), {31'd0, rsp_valid}, 32'd1);
         check($sformatf("bp_way_c%0d", c), {29'd0, rsp_way}, 32'd7);
         check($sformatf("bp_set_c%0d", c), {27'd0, rsp_set_idx}, 32'd9);
         check($sformatf("bp_ready_c%0d", c), {31'd0, req_ready}, 32'd0);
         check($sformatf("bp_ages_c%0d", c), {8'd0, mem_rd(9)}, {8'd0, ages(0, 7, 6, 5, 4, 3, 2, 1)});
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp2_way", {29'd0, rsp_way}, 32'd6);
      check("bp_ages2", {8'd0, mem_rd(9)}, {8'd0, ages(1, 0, 7, 6, 5, 4, 3, 2)});
      tick();
      check("bp_drain", {31'd0, rsp_valid}, 32'd0);

      // ---- reset with response and p1 both occupied, then reset again mid-INIT
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_ishit = 1'b0; req_way = 3'd0; req_set_idx = 5'd4;
      tick();
      req_set_idx = 5'd5;
      tick();
      req_valid = 1'b0;
      check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("mid_p1_blocked", {31'd0, req_ready}, 32'd0);
      reset = 1'b1;
      tick();
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
      check("mid_rst_no_wb", {8'd0, mem_rd(5)}, {8'd0, dflt});
      rsp_ready = 1'b1;
      reset = 1'b0;
      repeat (10) tick();
      check("mid_init_partial", {31'd0, init_done}, 32'd0);
      reset = 1'b1;
      tick();
      check("mid_init_rst_rsp", {31'd0, rsp_valid}, 32'd0);
      reset = 1'b0;
      check_init("reinit");
      check("reinit_set2", {8'd0, mem_rd(2)}, {8'd0, dflt});
      check("reinit_set3", {8'd0, mem_rd(3)}, {8'd0, dflt});
      check("reinit_set9", {8'd0, mem_rd(9)}, {8'd0, dflt});
      check("reinit_set31", {8'd0, mem_rd(31)}, {8'd0, dflt});

      // ---- lookup after re-init sees default ages again
      run_vec('{5'd3, 1'b0, 3'd0, 3'd7, ages(0, 7, 6, 5, 4, 3, 2, 1)}, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
